// File: rtl/serial_adder_ctrl_if.sv
// Operand/result bundle between a requester and the bit-serial adder controller.
// The requester drives operands and start; the controller returns status and result.
interface serial_adder_ctrl_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Cin;
   logic             sub;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] S;
   logic             Cout;
   logic             overflow;

   modport master (
      output start, A, B, Cin, sub,
      input  busy, done, S, Cout, overflow
   );

   modport slave (
      input  start, A, B, Cin, sub,
      output busy, done, S, Cout, overflow
   );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder/subtractor: streams operands LSB-first through one full-adder
// cell, one bit per clock, and assembles the parallel result at the end.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; only state in which a request is accepted
// RUN   | one operand bit per edge through the full adder, WIDTH edges
// DONE  | result valid, done pulse high for one cycle, then back to IDLE
module serial_adder_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic                clock,
   input  logic                reset_n,
   serial_adder_ctrl_if.slave  bus
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_MSB_IN = CW'(WIDTH - 2);
   localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] sum_sh;
   logic             carry;
   logic             c_msb_in;
   logic [CW-1:0]    cnt;

   logic fa_s;
   logic fa_c;

   assign fa_s = a_sh[0] ^ b_sh[0] ^ carry;
   assign fa_c = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         a_sh         <= '0;
         b_sh         <= '0;
         sum_sh       <= '0;
         carry        <= 1'b0;
         c_msb_in     <= 1'b0;
         cnt          <= '0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.S        <= '0;
         bus.Cout     <= 1'b0;
         bus.overflow <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  // Subtraction is A + ~B + 1, so invert B and force the carry-in.
                  a_sh     <= bus.A;
                  b_sh     <= bus.sub ? ~bus.B : bus.B;
                  carry    <= bus.sub ? 1'b1 : bus.Cin;
                  cnt      <= '0;
                  state    <= ST_RUN;
                  bus.busy <= 1'b1;
               end
            end
            ST_RUN: begin
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
               carry  <= fa_c;
               cnt    <= cnt + 1'b1;
               if (cnt == CNT_MSB_IN)
                  c_msb_in <= fa_c;
               if (cnt == CNT_LAST) begin
                  bus.S        <= {fa_s, sum_sh[WIDTH-1:1]};
                  bus.Cout     <= fa_c;
                  bus.overflow <= c_msb_in ^ fa_c;
                  bus.done     <= 1'b1;
                  state        <= ST_DONE;
               end
            end
            ST_DONE: begin
               bus.done <= 1'b0;
               bus.busy <= 1'b0;
               state    <= ST_IDLE;
            end
            default: begin
               bus.done <= 1'b0;
               bus.busy <= 1'b0;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl at WIDTH=8: directed operations push
// expected results; a monitor pops and compares whenever done is seen.
module tb_serial_adder_ctrl;

   localparam int W = 8;

   logic clock;
   logic reset_n;

   serial_adder_ctrl_if #(.WIDTH(W)) bus ();

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [W-1:0] s;
      logic         c;
      logic         o;
      int           acc;
      int           tag;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   bit   sim_end  = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // Monitor: compares each done against the head of the scoreboard, then
   // verifies that done lasts exactly one cycle and busy drops with it.
   initial begin : monitor
      exp_t e;
      bit   check_fall;
      check_fall = 0;
      while (!sim_end) begin
         @(negedge clock);
         if (check_fall) begin
            chk("done_width", {31'd0, bus.done}, 32'd0);
            chk("busy_after_done", {31'd0, bus.busy}, 32'd0);
            check_fall = 0;
         end else if (bus.done) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_done actual=1 required=0");
            end else begin
               e = sb.pop_front();
               chk($sformatf("S_%0d", e.tag), {24'd0, bus.S}, {24'd0, e.s});
               chk($sformatf("Cout_%0d", e.tag), {31'd0, bus.Cout}, {31'd0, e.c});
               chk($sformatf("ovf_%0d", e.tag), {31'd0, bus.overflow}, {31'd0, e.o});
               chk($sformatf("latency_%0d", e.tag), cyc - e.acc, W);
               chk($sformatf("busy_in_done_%0d", e.tag), {31'd0, bus.busy}, 32'd1);
            end
            check_fall = 1;
         end
      end
   end

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sb_sub, input logic [W-1:0] es, input logic ec,
                        input logic eo, input int tag, input bit push);
      exp_t e;
      @(negedge clock);
      bus.A     = a;
      bus.B     = b;
      bus.Cin   = cin;
      bus.sub   = sb_sub;
      bus.start = 1'b1;
      e.s = es; e.c = ec; e.o = eo; e.acc = cyc + 1; e.tag = tag;
      if (push) sb.push_back(e);
      @(negedge clock);
      bus.start = 1'b0;
      bus.A     = ~a;
      bus.B     = ~b;
      bus.Cin   = ~cin;
      bus.sub   = ~sb_sub;
   endtask

   task automatic wait_done(input int tag);
      int n;
      n = 0;
      while (!bus.done && n < 40) begin
         @(negedge clock);
         n++;
      end
      if (!bus.done) begin
         checks++;
         failures++;
         $display("FAIL timeout_%0d actual=no_done required=done", tag);
      end
      @(negedge clock);
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic sb_sub, input logic [W-1:0] es, input logic ec,
                         input logic eo, input int tag);
      issue(a, b, cin, sb_sub, es, ec, eo, tag, 1'b1);
      wait_done(tag);
   endtask

   initial begin : stim
      bus.start = 1'b0;
      bus.A     = '0;
      bus.B     = '0;
      bus.Cin   = 1'b0;
      bus.sub   = 1'b0;
      reset_n   = 1'b0;
      repeat (3) @(negedge clock);
      chk("rst_S", {24'd0, bus.S}, 32'd0);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_done", {31'd0, bus.done}, 32'd0);
      reset_n = 1'b1;
      @(negedge clock);

      run_op(8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 1);
      run_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2);
      run_op(8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, 3);
      run_op(8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, 4);
      run_op(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 5);

      // Second start mid-RUN must be ignored.
      issue(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 6, 1'b1);
      repeat (2) @(negedge clock);
      bus.A     = 8'hAA;
      bus.B     = 8'h01;
      bus.sub   = 1'b0;
      bus.Cin   = 1'b0;
      bus.start = 1'b1;
      @(negedge clock);
      bus.start = 1'b0;
      wait_done(6);
      repeat (3) @(negedge clock);
      chk("no_restart_busy", {31'd0, bus.busy}, 32'd0);

      // Abort mid-RUN with reset: no done, outputs cleared at once.
      @(negedge clock);
      bus.A     = 8'h10;
      bus.B     = 8'h10;
      bus.Cin   = 1'b0;
      bus.sub   = 1'b0;
      bus.start = 1'b1;
      repeat (5) @(posedge clock);
      #1;
      bus.start = 1'b0;
      chk("busy_before_abort", {31'd0, bus.busy}, 32'd1);
      reset_n = 1'b0;
      #1;
      chk("abort_S", {24'd0, bus.S}, 32'd0);
      chk("abort_Cout", {31'd0, bus.Cout}, 32'd0);
      chk("abort_ovf", {31'd0, bus.overflow}, 32'd0);
      chk("abort_busy", {31'd0, bus.busy}, 32'd0);
      chk("abort_done", {31'd0, bus.done}, 32'd0);
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      repeat (12) @(negedge clock);
      chk("post_abort_busy", {31'd0, bus.busy}, 32'd0);

      run_op(8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0, 7);

      repeat (3) @(negedge clock);
      chk("scoreboard_empty", sb.size(), 32'd0);
      sim_end = 1;
      @(negedge clock);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder/subtractor. It accepts two WIDTH-bit operands on a start pulse and streams them LSB-first through a single one-bit full-adder cell, one bit per clock. A carry flip-flop links successive bits. The block sits directly upstream of the one-bit adder cell: it sequences operand bits and carry into that cell, then collects the sum bits and final carry into a parallel result. It trades latency for area against the ripple-carry datapath.

## Interface
- WIDTH, 32, operand and result width in bits (≥ 2)
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- A  in  WIDTH  operand A; captured on accepted start
- B  in  WIDTH  operand B; captured on accepted start
- Cin  in  1  carry-in for add; captured on accepted start; ignored when sub=1
- sub  in  1  0 = A+B+Cin, 1 = A−B (≡ A + ~B + 1); captured on accepted start
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse, high exactly while in DONE
- S  out  WIDTH  registered result; holds value until next DONE
- Cout  out  1  final carry-out (for sub: 1 = no borrow)
- overflow  out  1  signed overflow = carry into MSB XOR carry out of MSB

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - start=1 at an edge: load shift register a_sh←A and b_sh←(sub ? ~B : B).
  - Same edge: carry←(sub ? 1 : Cin), bit counter←0, go to RUN.
  - start=0: stay in IDLE.
- RUN, each edge:
  - Full adder computes s=a_sh[0]^b_sh[0]^carry and c=majority(a_sh[0],b_sh[0],carry).
  - s shifts into sum_sh MSB end; a_sh and b_sh shift right; carry←c; counter increments.
  - On the edge where counter==WIDTH−2, also latch c into c_msb_in. This is the carry into the MSB.
  - On the edge where counter==WIDTH−1:
    - S←final assembled sum.
    - Cout←c.
    - overflow←c_msb_in^c.
    - Go to DONE.
- DONE: lasts one cycle, then go to IDLE unconditionally.
- start outside IDLE is ignored. It is neither queued nor restarted. It is also ignored in DONE; a request is accepted only on an edge in IDLE.
- S, Cout and overflow change only on the RUN→DONE edge. Partial sums are never visible on S.
- Counter width is clog2(WIDTH). No wrap occurs, because the state leaves RUN at WIDTH−1.
- Reset, asserted any time including mid-RUN:
  - Immediately: state←IDLE; S, Cout, overflow, busy, done←0.
  - All internal shift registers, carry and counter←0.
  - An aborted operation produces no done.

## Timing
- Start accepted at edge E0. Bits are processed on edges E1..EWIDTH.
- done and busy come from the registered state.
  - busy rises after E0.
  - done and valid S rise after EWIDTH and fall after EWIDTH+1.
  - busy falls after EWIDTH+1.
- Latency from accepting edge to done visible: WIDTH cycles. Throughput: one operation per WIDTH+2 cycles.
- Earliest next accept is the edge EWIDTH+2, the first edge seen in IDLE.
- Inputs A, B, Cin and sub may change freely after E0.

## Test plan
Run with WIDTH=8. Each case checks that done rises exactly 8 cycles after the accepting edge.

- A=8'h0F, B=8'h01, Cin=0, sub=0 → S=8'h10, Cout=0, overflow=0; done high for exactly 1 cycle.
- A=8'hFF, B=8'h01, Cin=0, sub=0 → S=8'h00, Cout=1, overflow=0.
- A=8'h7F, B=8'h00, Cin=1, sub=0 → S=8'h80, Cout=0, overflow=1.
- A=8'h05, B=8'h07, sub=1, Cin=1 (ignored) → S=8'hFE, Cout=0, overflow=0.
- A=8'h80, B=8'h01, sub=1 → S=8'h7F, Cout=1, overflow=1.
- Busy and reset behaviour:
  - Start 8'h01+8'h01. Pulse start again with A=8'hAA mid-RUN → result still S=8'h02; the second start is ignored.
  - Then start 8'h10+8'h10 and pull reset_n low at the 4th RUN edge → all outputs 0 immediately, no done.
  - After release, 8'h03+8'h04 → S=8'h07.
